ha_array_reducer: RTL and testbench

Back-end reduction stage for the unsigned 8x8 ha_array multiplier family. Accepts the four half-adder-compressed row pairs (ha_array_0..3, each a 7-bit carry vector b and 9-bit sum vector t) that the front-end generators emit, and accumulates them over several cycles into a 16-bit product. It uses a valid/ready handshake on both sides, so any ha_array front-end can be paired with it, exact or approximate.

---
 rtl/ha_array_reducer.sv | 104 ++++++++++
 tb/tb_ha_array_reducer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ha_array_reducer.sv
// Accumulates four half-adder-compressed row pairs into a saturated 16-bit product.
// Latency 4/ROWS_PER_CYCLE cycles after accept; in_ready low until the result handshake completes.
module ha_array_reducer #(
    parameter int ROWS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  ha_array_0_b,
    input  logic [8:0]  ha_array_0_t,
    input  logic [6:0]  ha_array_1_b,
    input  logic [8:0]  ha_array_1_t,
    input  logic [6:0]  ha_array_2_b,
    input  logic [8:0]  ha_array_2_t,
    input  logic [6:0]  ha_array_3_b,
    input  logic [8:0]  ha_array_3_t,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] p,
    output logic        p_ovf
);

    if (ROWS_PER_CYCLE != 1 && ROWS_PER_CYCLE != 2 && ROWS_PER_CYCLE != 4) begin : g_bad_rpc
        $error("ha_array_reducer: ROWS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    localparam logic [1:0] CNT_STEP = 2'(ROWS_PER_CYCLE);
    localparam logic [1:0] CNT_LAST = 2'(4 - ROWS_PER_CYCLE);

    state_t      state_q, state_d;
    logic [63:0] rows_q, rows_d;
    logic [16:0] acc_q, acc_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [16:0] row_val [4];
    logic [16:0] add_val;

    // Row k occupies rows_q[16k +: 16] as {b[6:0], t[8:0]}.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            row_val[k] = ({8'd0, rows_q[16*k +: 9]} + {8'd0, rows_q[16*k+9 +: 7], 2'b00}) << (2*k);
        end
    end

    always_comb begin
        add_val = '0;
        for (int j = 0; j < ROWS_PER_CYCLE; j++) begin
            add_val = add_val + row_val[cnt_q + 2'(j)];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rows_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rows_q  <= rows_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = ACC;
            ACC:     if (cnt_q == CNT_LAST) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rows_d = rows_q;
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        if (state_q == IDLE && in_valid) begin
            rows_d = {ha_array_3_b, ha_array_3_t, ha_array_2_b, ha_array_2_t,
                      ha_array_1_b, ha_array_1_t, ha_array_0_b, ha_array_0_t};
            acc_d  = '0;
            cnt_d  = '0;
        end else if (state_q == ACC) begin
            acc_d = acc_q + add_val;
            cnt_d = cnt_q + CNT_STEP;
        end
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        p         = 16'h0000;
        p_ovf     = 1'b0;
        if (state_q == DONE) begin
            p     = acc_q[16] ? 16'hFFFF : acc_q[15:0];
            p_ovf = acc_q[16];
        end
    end

endmodule

// File: tb/tb_ha_array_reducer.sv
// Scoreboard bench: directed vectors on ROWS_PER_CYCLE=1, random exact rows on 2 and 4.
module tb_ha_array_reducer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;
    bit start_dir  = 1'b0;
    bit start_rand = 1'b0;
    bit dir_done   = 1'b0;
    bit rnd_done [3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // Exact half-adder compression of partial-product rows 2k and 2k+1.
    function automatic logic [63:0] exact(input logic [7:0] x, input logic [7:0] y);
        logic [63:0] v;
        logic [7:0]  a;
        logic [8:0]  c, t;
        logic [6:0]  b;
        v = '0;
        for (int k = 0; k < 4; k++) begin
            a = x & {8{y[2*k]}};
            c = {x & {8{y[2*k+1]}}, 1'b0};
            t = {1'b0, a} ^ c;
            b = a[7:1] & c[7:1];
            v[16*k +: 9]   = t;
            v[16*k+9 +: 7] = b;
        end
        return v;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int RPC = 1 << g;
        localparam int LAT = 4 / RPC;

        logic        in_valid, in_ready, out_valid, out_ready, p_ovf;
        logic [15:0] p;
        logic [63:0] rows;

        ha_array_reducer #(.ROWS_PER_CYCLE(RPC)) u_dut (
            .clk          (clk),
            .rst          (rst),
            .in_valid     (in_valid),
            .in_ready     (in_ready),
            .ha_array_0_b (rows[15:9]),
            .ha_array_0_t (rows[8:0]),
            .ha_array_1_b (rows[31:25]),
            .ha_array_1_t (rows[24:16]),
            .ha_array_2_b (rows[47:41]),
            .ha_array_2_t (rows[40:32]),
            .ha_array_3_b (rows[63:57]),
            .ha_array_3_t (rows[56:48]),
            .out_valid    (out_valid),
            .out_ready    (out_ready),
            .p            (p),
            .p_ovf        (p_ovf)
        );

        logic [16:0] exp_q [$];
        int          acc_cyc   = 0;
        logic        ov_prev   = 1'b0;
        logic        ordy_prev = 1'b0;
        logic [16:0] res_prev  = '0;

        always @(negedge clk) begin
            logic [16:0] e;
            if (!rst) begin
                if (ov_prev && !ordy_prev) begin
                    check("hold_valid", out_valid, 1);
                    check("hold_result", {p_ovf, p}, res_prev);
                end
                if (out_valid && !ov_prev) check("latency", cyc - acc_cyc - 1, LAT);
                if (in_valid && in_ready) acc_cyc = cyc;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) check("queue_size", exp_q.size(), 1);
                    else begin
                        e = exp_q.pop_front();
                        check("p", p, e[15:0]);
                        check("p_ovf", p_ovf, e[16]);
                    end
                end
            end
            ov_prev   = out_valid;
            ordy_prev = out_ready;
            res_prev  = {p_ovf, p};
        end

        // Called at posedge+1; returns at posedge+1 just after the accept edge.
        task automatic send(input logic [63:0] v, input logic [16:0] e, input bit push);
            int n;
            rows     = v;
            in_valid = 1'b1;
            n = 0;
            @(negedge clk);
            while (!in_ready && n < 20) begin
                n++;
                @(negedge clk);
            end
            check("accept_ready", in_ready, 1);
            @(posedge clk);
            if (push) exp_q.push_back(e);
            #1 in_valid = 1'b0;
        endtask

        task automatic wait_idle(output int n);
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!in_ready && n < 50);
            @(posedge clk);
            #1;
        endtask

        if (g == 0) begin : g_dir
            logic [63:0] vt [6];
            logic [16:0] et [6];
            initial begin
                int n;
                in_valid  = 1'b0;
                out_ready = 1'b1;
                rows      = '0;
                vt[0] = 64'h0;                          et[0] = 17'h00000;
                vt[1] = 64'h1;                          et[1] = 17'h00001;
                vt[2] = (64'h1 << 18) | (64'h1 << 26);  et[2] = 17'h00030;
                vt[3] = (64'h1 << 56) | (64'h1 << 63);  et[3] = 17'h08000;
                vt[4] = {64{1'b1}};                     et[4] = 17'h1FFFF;
                vt[5] = exact(8'd255, 8'd255);          et[5] = 17'h0FE01;
                wait (start_dir);
                @(negedge clk);
                check("rst_in_ready", in_ready, 1);
                check("rst_out_valid", out_valid, 0);
                check("rst_p", p, 0);
                check("rst_p_ovf", p_ovf, 0);
                @(posedge clk);
                #1;
                for (int i = 0; i < 6; i++) begin
                    send(vt[i], et[i], 1'b1);
                    wait_idle(n);
                    check("idle_return", n, LAT + 2);
                end

                out_ready = 1'b0;
                send(exact(8'd7, 8'd9), 17'd63, 1'b1);
                n = 0;
                @(negedge clk);
                while (!out_valid && n < 20) begin
                    n++;
                    @(negedge clk);
                end
                for (int i = 0; i < 10; i++) begin
                    @(posedge clk);
                    #1 rows = {$urandom, $urandom};
                    @(negedge clk);
                    check("bp_valid", out_valid, 1);
                    check("bp_p", p, 16'd63);
                    check("bp_in_ready", in_ready, 0);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
                @(negedge clk);
                @(negedge clk);
                check("bp_release", out_valid, 0);
                @(posedge clk);
                #1;

                send(exact(8'd200, 8'd100), 17'd0, 1'b0);
                @(posedge clk);
                #1 rst = 1'b1;
                @(posedge clk);
                #1 rst = 1'b0;
                @(negedge clk);
                check("midrst_out_valid", out_valid, 0);
                check("midrst_p", p, 0);
                check("midrst_in_ready", in_ready, 1);

                @(posedge clk);
                #1;
                rst      = 1'b1;
                in_valid = 1'b1;
                rows     = exact(8'd3, 8'd5);
                @(posedge clk);
                #1;
                rst      = 1'b0;
                in_valid = 1'b0;
                @(negedge clk);
                check("rst_vld_not_taken", in_ready, 1);
                @(posedge clk);
                #1;
                send(exact(8'd3, 8'd5), 17'h0000F, 1'b1);
                wait_idle(n);
                check("idle_return", n, LAT + 2);
                dir_done = 1'b1;
            end
        end else begin : g_rnd
            initial begin
                int n, last;
                logic [7:0]  x, y;
                logic [15:0] pr;
                in_valid  = 1'b0;
                out_ready = 1'b1;
                rows      = '0;
                last      = 0;
                wait (start_rand);
                @(posedge clk);
                #1;
                for (int i = 0; i < 1000; i++) begin
                    x  = 8'($urandom_range(0, 255));
                    y  = 8'($urandom_range(0, 255));
                    pr = x * y;
                    rows     = exact(x, y);
                    in_valid = 1'b1;
                    n = 0;
                    @(negedge clk);
                    while (!in_ready && n < 20) begin
                        n++;
                        @(negedge clk);
                    end
                    if (!in_ready) check("rnd_accept", in_ready, 1);
                    @(posedge clk);
                    exp_q.push_back({1'b0, pr});
                    #1;
                    if (i > 0) check("throughput", cyc - last, LAT + 2);
                    last = cyc;
                end
                in_valid = 1'b0;
                repeat (10) @(posedge clk);
                rnd_done[g] = 1'b1;
            end
        end
    end

    initial begin
        int n;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        start_dir = 1'b1;
        n = 0;
        while (!dir_done && n < 2000) begin
            @(posedge clk);
            n++;
        end
        check("dir_done", dir_done, 1);
        start_rand = 1'b1;
        n = 0;
        while (!(rnd_done[1] && rnd_done[2]) && n < 20000) begin
            @(posedge clk);
            n++;
        end
        check("rnd_done", rnd_done[1] && rnd_done[2], 1);
        repeat (5) @(posedge clk);
        check("drain_rpc1", g_dut[0].exp_q.size(), 0);
        check("drain_rpc2", g_dut[1].exp_q.size(), 0);
        check("drain_rpc4", g_dut[2].exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
